// File: rtl/ram_window_fetcher.sv
// Arbitrates the single-port byte RAM between a byte-write requester and a
// KxK (K=3/5) convolution-window fetcher that gathers rows into a 25-byte bus.
module ram_window_fetcher #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int WIDTH_W = 10
) (
  input  logic                  clk_c,
  input  logic                  reset_in,
  input  logic                  fetch_req_in,
  output logic                  fetch_ack_out,
  input  logic                  kernel5_in,
  input  logic [ADDR_W-1:0]     base_addr_in,
  input  logic [WIDTH_W-1:0]    img_width_in,
  input  logic                  wr_req_in,
  output logic                  wr_ack_out,
  input  logic [ADDR_W-1:0]     wr_addr_in,
  input  logic [DATA_W-1:0]     wr_data_in,
  output logic                  ram_enable_out,
  output logic                  ram_read_write_out,
  output logic [ADDR_W-1:0]     ram_address_out,
  output logic [DATA_W-1:0]     ram_data_out,
  input  logic [5*DATA_W-1:0]   ram_row_in,
  output logic [25*DATA_W-1:0]  window_out,
  output logic                  window_valid_out,
  output logic                  busy_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
  typedef enum logic {GRANT_WRITE, GRANT_FETCH} grant_t;

  state_t               state_q, state_d;
  grant_t               last_q, last_d;
  logic                 k5_q, k5_d;
  logic [ADDR_W-1:0]    row_addr_q, row_addr_d;
  logic [WIDTH_W-1:0]   width_q, width_d;
  logic [2:0]           row_q, row_d;
  logic [25*DATA_W-1:0] window_q, window_d;
  logic                 grant_wr, grant_fetch;
  logic [2:0]           last_row;

  // Round-robin: on contention the requester not granted last wins.
  assign grant_wr    = !reset_in && wr_req_in &&
                       (!fetch_req_in || last_q == GRANT_FETCH);
  assign grant_fetch = !reset_in && fetch_req_in &&
                       (!wr_req_in || last_q == GRANT_WRITE);
  assign last_row    = k5_q ? 3'd4 : 3'd2;

  always_comb begin
    state_d            = state_q;
    last_d             = last_q;
    k5_d               = k5_q;
    row_addr_d         = row_addr_q;
    width_d            = width_q;
    row_d              = row_q;
    window_d           = window_q;
    fetch_ack_out      = 1'b0;
    wr_ack_out         = 1'b0;
    ram_enable_out     = 1'b0;
    ram_read_write_out = 1'b1;
    ram_address_out    = '0;
    ram_data_out       = '0;
    window_valid_out   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          ram_enable_out     = 1'b1;
          ram_read_write_out = 1'b0;
          ram_address_out    = wr_addr_in;
          ram_data_out       = wr_data_in;
          wr_ack_out         = 1'b1;
          last_d             = GRANT_WRITE;
        end else if (grant_fetch) begin
          fetch_ack_out = 1'b1;
          k5_d          = kernel5_in;
          row_addr_d    = base_addr_in;
          width_d       = img_width_in;
          window_d      = '0;
          row_d         = '0;
          last_d        = GRANT_FETCH;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        ram_enable_out  = 1'b1;
        ram_address_out = row_addr_q;
        state_d         = CAPTURE;
      end
      CAPTURE: begin
        ram_enable_out  = 1'b1;
        ram_address_out = row_addr_q;
        // Unrolled so every window slice uses a constant index.
        for (int unsigned r = 0; r < 5; r++) begin
          for (int unsigned c = 0; c < 5; c++) begin
            if (3'(r) == row_q && c < (k5_q ? 5 : 3))
              window_d[(5*r+c)*DATA_W +: DATA_W] = ram_row_in[c*DATA_W +: DATA_W];
          end
        end
        row_addr_d = row_addr_q + ADDR_W'(width_q);
        row_d      = row_q + 3'd1;
        state_d    = (row_q == last_row) ? DONE : ISSUE;
      end
      DONE: begin
        window_valid_out = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_c) begin
    if (reset_in) begin
      state_q    <= IDLE;
      last_q     <= GRANT_FETCH;
      k5_q       <= 1'b0;
      row_addr_q <= '0;
      width_q    <= '0;
      row_q      <= '0;
      window_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      k5_q       <= k5_d;
      row_addr_q <= row_addr_d;
      width_q    <= width_d;
      row_q      <= row_d;
      window_q   <= window_d;
    end
  end

  assign window_out = window_q;
  assign busy_out   = (state_q != IDLE);

endmodule

// File: tb/tb_ram_window_fetcher.sv
// Directed bench for ram_window_fetcher with a behavioural synchronous RAM
// that returns 5 consecutive bytes one cycle after a read is issued.
module tb_ram_window_fetcher;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         fetch_req = 1'b0, fetch_ack, kernel5 = 1'b0;
  logic [18:0]  base_addr = '0;
  logic [9:0]   img_width = '0;
  logic         wr_req = 1'b0, wr_ack;
  logic [18:0]  wr_addr = '0;
  logic [7:0]   wr_data = '0;
  logic         ram_en, ram_rw;
  logic [18:0]  ram_addr;
  logic [7:0]   ram_wdata;
  logic [39:0]  ram_row = '0;
  logic [199:0] window;
  logic         valid, busy;

  logic [7:0]   mem [0:(1<<19)-1];
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  ram_window_fetcher #(.ADDR_W(19), .DATA_W(8), .WIDTH_W(10)) dut (
    .clk_c(clk), .reset_in(reset),
    .fetch_req_in(fetch_req), .fetch_ack_out(fetch_ack), .kernel5_in(kernel5),
    .base_addr_in(base_addr), .img_width_in(img_width),
    .wr_req_in(wr_req), .wr_ack_out(wr_ack), .wr_addr_in(wr_addr), .wr_data_in(wr_data),
    .ram_enable_out(ram_en), .ram_read_write_out(ram_rw), .ram_address_out(ram_addr),
    .ram_data_out(ram_wdata), .ram_row_in(ram_row),
    .window_out(window), .window_valid_out(valid), .busy_out(busy)
  );

  always @(posedge clk) begin
    if (ram_en && !ram_rw) mem[ram_addr] <= ram_wdata;
    if (ram_en && ram_rw)
      ram_row <= {mem[ram_addr+19'd4], mem[ram_addr+19'd3], mem[ram_addr+19'd2],
                  mem[ram_addr+19'd1], mem[ram_addr]};
  end

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {ram_en, ram_rw, ram_addr, ram_wdata, fetch_ack, wr_ack, valid, busy},
        {1'b0, 1'b1, 19'd0, 8'd0, 4'b0000});
  endtask

  // Fetch whose grant cycle T is the first cycle; checks every cycle to T+2K+2.
  task automatic run_fetch(input string tag, input logic [18:0] base, input logic [9:0] w,
                           input logic k5, input int k, input logic [18:0] ea [5]);
    @(negedge clk); fetch_req = 1'b1; base_addr = base; img_width = w; kernel5 = k5; #1;
    chk({tag, "_ack"}, fetch_ack, 1'b1);
    chk({tag, "_busyT"}, busy, 1'b0);
    for (int i = 1; i <= 2*k; i++) begin
      @(negedge clk);
      if (i == 1) begin
        fetch_req = 1'b0; base_addr = 19'h1234; img_width = 10'd7; kernel5 = ~k5;
      end
      #1;
      chk({tag, "_addr"}, ram_addr, ea[(i-1)/2]);
      chk({tag, "_rd"}, {ram_en, ram_rw, busy, valid, fetch_ack}, 5'b11100);
    end
    @(negedge clk); #1;
    chk({tag, "_done"}, {valid, busy, ram_en}, 3'b110);
    @(negedge clk); #1;
    chk({tag, "_after"}, {valid, busy}, 2'b00);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20) begin @(negedge clk); #1; n++; end
    if (busy) chk({tag, "_timeout"}, busy, 1'b0);
  endtask

  initial begin
    logic [18:0]  ea [5];
    logic [199:0] ew;
    logic [199:0] w_keep;
    for (int i = 0; i < (1<<19); i++) mem[i] = 8'h00;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) mem[100 + 32*r + c] = 8'(16*r + c);
    for (int c = 0; c < 5; c++) begin
      mem[19'h7FFF0 + c] = 8'(8'hA0 + c);
      mem[c]             = 8'(8'hB0 + c);
      mem[19'h10 + c]    = 8'(8'hC0 + c);
    end

    // 1: reset and quiet
    repeat (2) @(negedge clk);
    #1 chk_idle("in_reset");
    chk("in_reset_win", window, '0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk_idle("reset_idle");
      chk("reset_win", window, '0);
    end

    // 2: 3x3 fetch
    ea = '{19'd100, 19'd132, 19'd164, 19'd0, 19'd0};
    run_fetch("k3", 19'd100, 10'd32, 1'b0, 3, ea);
    ew = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) ew[(5*r+c)*8 +: 8] = 8'(16*r + c);
    chk("k3_window", window, ew);
    chk("k3_w12", window[(5*1+2)*8 +: 8], 8'h12);
    chk("k3_w03", window[(5*0+3)*8 +: 8], 8'h00);
    chk("k3_w44", window[(5*4+4)*8 +: 8], 8'h00);

    // 3: 5x5 fetch
    ea = '{19'd100, 19'd132, 19'd164, 19'd196, 19'd228};
    run_fetch("k5", 19'd100, 10'd32, 1'b1, 5, ea);
    ew = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) ew[(5*r+c)*8 +: 8] = 8'(16*r + c);
    chk("k5_window", window, ew);
    chk("k5_w44", window[(5*4+4)*8 +: 8], 8'h44);
    @(negedge clk); #1;
    chk("k5_hold", window, ew);

    // 4: simultaneous requests after reset -> write first, then fetch
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    @(negedge clk);
    wr_req = 1'b1; wr_addr = 19'h300; wr_data = 8'h3C;
    fetch_req = 1'b1; base_addr = 19'd100; img_width = 10'd32; kernel5 = 1'b0; #1;
    chk("rr4_T", {wr_ack, fetch_ack, ram_en, ram_rw, ram_addr, ram_wdata},
        {4'b1010, 19'h300, 8'h3C});
    @(negedge clk); #1;
    chk("rr4_T1", {wr_ack, fetch_ack, busy}, 3'b010);
    chk("rr4_mem", mem[19'h300], 8'h3C);
    @(negedge clk); wr_req = 1'b0; fetch_req = 1'b0; #1;
    wait_idle("rr4");

    // 5: after a completed fetch grant the write wins again
    @(negedge clk);
    wr_req = 1'b1; wr_addr = 19'h301; wr_data = 8'hC3; fetch_req = 1'b1; #1;
    chk("rr5_T", {wr_ack, fetch_ack}, 2'b10);
    @(negedge clk); wr_req = 1'b0; #1;
    chk("rr5_T1", {wr_ack, fetch_ack}, 2'b01);
    @(negedge clk); fetch_req = 1'b0; #1;
    wait_idle("rr5");
    chk("rr5_mem", mem[19'h301], 8'hC3);

    // 6: write held during a 3x3 fetch is acked in the first IDLE cycle
    @(negedge clk); fetch_req = 1'b1; kernel5 = 1'b0; #1;
    chk("hold_fack", fetch_ack, 1'b1);
    @(negedge clk); fetch_req = 1'b0; wr_req = 1'b1; wr_addr = 19'h200; wr_data = 8'h5A;
    #1 chk("hold_nowr", wr_ack, 1'b0);
    for (int i = 2; i <= 7; i++) begin
      @(negedge clk); #1;
      chk("hold_nowr", {wr_ack, busy}, 2'b01);
    end
    @(negedge clk); #1;
    chk("hold_wr", {wr_ack, busy, ram_en, ram_rw, ram_addr}, {4'b1010, 19'h200});
    @(negedge clk); wr_req = 1'b0; #1;
    chk("hold_mem", mem[19'h200], 8'h5A);

    // 7: address wrap
    ea = '{19'h7FFF0, 19'h00000, 19'h00010, 19'd0, 19'd0};
    run_fetch("wrap", 19'h7FFF0, 10'd16, 1'b0, 3, ea);
    ew = '0;
    for (int c = 0; c < 3; c++) begin
      ew[(5*0+c)*8 +: 8] = 8'(8'hA0 + c);
      ew[(5*1+c)*8 +: 8] = 8'(8'hB0 + c);
      ew[(5*2+c)*8 +: 8] = 8'(8'hC0 + c);
    end
    chk("wrap_window", window, ew);

    // 8: reset during the second CAPTURE
    @(negedge clk); fetch_req = 1'b1; base_addr = 19'd100; img_width = 10'd32; kernel5 = 1'b0;
    #1 chk("rst_fack", fetch_ack, 1'b1);
    @(negedge clk); fetch_req = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("rst_cap2", {busy, ram_addr}, {1'b1, 19'd132});
    w_keep = window;
    chk("rst_row0", w_keep[(5*0+2)*8 +: 8], 8'h02);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_win", window, '0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      chk("rst_novalid", {valid, busy}, 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
